// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared register-file write definitions used by the writeback stage, the
//   register file and the rf_write_arbiter.
//   DATA_W  : register data width
//   ADDR_W  : register address width (2**ADDR_W registers)
//   rf_wr_t : one register-file write {dest, data}
package mips_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/mdu_result_fifo.sv
// mdu_result_fifo
//   Small circular FIFO holding completed MDU results until the register-file
//   write port is free.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, wr_i  : enqueue wr_i (ignored while full)
//   pop_i         : dequeue the head entry (ignored while empty)
//   head_o        : oldest entry, valid while empty_o is low
//   empty_o       : no entries held
//   count_o       : number of entries held (0..DEPTH)
module mdu_result_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  rf_wr_t        wr_i,
  input  logic          pop_i,
  output rf_wr_t        head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  rf_wr_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_s    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign push_ok_s = push_i & ~full_s;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so stale results never reappear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Owns the single register-file write port. Writeback always wins; MDU
//   results queue in mdu_result_fifo and drain into cycles where WB is idle.
//   A busy scoreboard stalls decode on registers awaiting MDU results, and a
//   starvation counter raises hold_pipe so queued results eventually drain.
//   DATA_W/ADDR_W must match mips_pkg, which defines the FIFO entry type.
//   clk, rst                 : clock, asynchronous active-low reset
//   wb_write_*               : writeback stage write request
//   mdu_issue, mdu_issue_dest: MDU op issued by decode (marks dest busy)
//   mdu_valid/dest/data      : MDU result, accepted when mdu_ready
//   id_rs1/rs2/rd, id_valid  : decode operands; id_stall when any is busy
//   hold_pipe                : request a pipeline bubble for the MDU
//   rf_we/rf_waddr/rf_wdata  : register-file write port
//   busy_vec                 : scoreboard contents
module rf_write_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W       = mips_pkg::DATA_W,
  parameter int ADDR_W       = mips_pkg::ADDR_W,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_write_en,
  input  logic [ADDR_W-1:0]    wb_write_dest,
  input  logic [DATA_W-1:0]    wb_write_data,
  input  logic                 mdu_issue,
  input  logic [ADDR_W-1:0]    mdu_issue_dest,
  input  logic                 mdu_valid,
  input  logic [ADDR_W-1:0]    mdu_dest,
  input  logic [DATA_W-1:0]    mdu_data,
  output logic                 mdu_ready,
  input  logic [ADDR_W-1:0]    id_rs1,
  input  logic [ADDR_W-1:0]    id_rs2,
  input  logic [ADDR_W-1:0]    id_rd,
  input  logic                 id_valid,
  output logic                 id_stall,
  output logic                 hold_pipe,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [2**ADDR_W-1:0] busy_vec
);

  localparam int NREG = 2**ADDR_W;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  rf_wr_t          mdu_wr_s;
  rf_wr_t          head_s;
  logic            fifo_empty_s;
  logic [CW-1:0]   fifo_count_s;
  logic            push_s;
  logic            drain_s;
  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_mask_s, clr_mask_s;
  logic [SW-1:0]   starve_q, starve_d;
  logic            hold_q, hold_d;

  // Ready ignores a same-cycle drain, so it only depends on registered occupancy.
  assign mdu_ready     = (fifo_count_s < DEPTH_C);
  assign push_s        = mdu_valid & mdu_ready;
  assign drain_s       = ~wb_write_en & ~fifo_empty_s;
  assign mdu_wr_s.dest = mdu_dest;
  assign mdu_wr_s.data = mdu_data;

  mdu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push_s),
    .wr_i    (mdu_wr_s),
    .pop_i   (drain_s),
    .head_o  (head_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Write-port mux: WB first, then the FIFO head, otherwise idle with zeroed fields.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = {ADDR_W{1'b0}};
    rf_wdata = {DATA_W{1'b0}};
    if (wb_write_en) begin
      rf_we    = 1'b1;
      rf_waddr = wb_write_dest;
      rf_wdata = wb_write_data;
    end else if (!fifo_empty_s) begin
      rf_we    = 1'b1;
      rf_waddr = head_s.dest;
      rf_wdata = head_s.data;
    end else begin
      rf_we    = 1'b0;
      rf_waddr = {ADDR_W{1'b0}};
      rf_wdata = {DATA_W{1'b0}};
    end
  end

  // Scoreboard next-state; OR-ing the set mask last makes a same-cycle issue win over a drain.
  always_comb begin
    set_mask_s = {NREG{1'b0}};
    clr_mask_s = {NREG{1'b0}};
    if (mdu_issue) begin
      set_mask_s = NREG'(1) << mdu_issue_dest;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (drain_s) begin
      clr_mask_s = NREG'(1) << head_s.dest;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    busy_d = (busy_q & ~clr_mask_s) | set_mask_s;
  end

  // Starvation counter: counts WB-won cycles while results wait, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty_s || drain_s) begin
      starve_d = {SW{1'b0}};
    end else if (wb_write_en && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
    hold_d = (starve_d == STARVE_MAX);
  end

  // Scoreboard, starvation counter and hold request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= {NREG{1'b0}};
      starve_q <= {SW{1'b0}};
      hold_q   <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  // id_rd is checked too so a WB write cannot be overtaken by an older MDU result.
  assign id_stall  = id_valid & (busy_q[id_rs1] | busy_q[id_rs2] | busy_q[id_rd]);
  assign hold_pipe = hold_q;
  assign busy_vec  = busy_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_write_en;
  logic [AW-1:0] wb_write_dest;
  logic [DW-1:0] wb_write_data;
  logic          mdu_issue;
  logic [AW-1:0] mdu_issue_dest;
  logic          mdu_valid;
  logic [AW-1:0] mdu_dest;
  logic [DW-1:0] mdu_data;
  logic          mdu_ready;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_valid;
  logic          id_stall;
  logic          hold_pipe;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [7:0]    busy_vec;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mfifo[$];
  int  total = 0;
  int  bad   = 0;
  bit  sb_on = 1'b0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .wb_write_en    (wb_write_en),
    .wb_write_dest  (wb_write_dest),
    .wb_write_data  (wb_write_data),
    .mdu_issue      (mdu_issue),
    .mdu_issue_dest (mdu_issue_dest),
    .mdu_valid      (mdu_valid),
    .mdu_dest       (mdu_dest),
    .mdu_data       (mdu_data),
    .mdu_ready      (mdu_ready),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_valid       (id_valid),
    .id_stall       (id_stall),
    .hold_pipe      (hold_pipe),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .busy_vec       (busy_vec)
  );

  task automatic idle();
    wb_write_en    = 1'b0;
    wb_write_dest  = 3'd0;
    wb_write_data  = 16'h0000;
    mdu_issue      = 1'b0;
    mdu_issue_dest = 3'd0;
    mdu_valid      = 1'b0;
    mdu_dest       = 3'd0;
    mdu_data       = 16'h0000;
    id_rs1         = 3'd0;
    id_rs2         = 3'd0;
    id_rd          = 3'd0;
    id_valid       = 1'b0;
  endtask

  // Reference model for the current cycle's inputs, then advance one clock.
  task automatic tick();
    wr_t e;
    bit  ready;
    ready = (mfifo.size() < 2);
    if (wb_write_en) begin
      e.a = wb_write_dest;
      e.d = wb_write_data;
      exp_q.push_back(e);
    end else if (mfifo.size() != 0) begin
      exp_q.push_back(mfifo.pop_front());
    end
    if (mdu_valid && ready) begin
      e.a = mdu_dest;
      e.d = mdu_data;
      mfifo.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every register-file write must match the next expected write.
  task automatic sb_monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (sb_on) begin
        if (rf_we) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
          end else begin
            e = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== {e.a, e.d}) begin
              bad++;
              $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                       rf_waddr, rf_wdata, e.a, e.d);
            end
          end
        end else if (exp_q.size() != 0) begin
          total++;
          bad++;
          e = exp_q.pop_front();
          $display("FAIL sb_missing_write: got rf_we=0, required addr=%0d data=%h", e.a, e.d);
          exp_q.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    id_valid = 1'b1;
    #12;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b required 1", mdu_ready); end
    total++; if (busy_vec !== 8'h00) begin bad++; $display("FAIL rst_busy: got %h required 00", busy_vec); end
    total++; if (hold_pipe !== 1'b0) begin bad++; $display("FAIL rst_hold: got %b required 0", hold_pipe); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b required 0", rf_we); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b required 0", id_stall); end
    wb_write_en = 1'b1;
    #1;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL rst_we_follows_wb: got %b required 1", rf_we); end
    idle();
    @(posedge clk);
    #1;
    rst   = 1'b1;
    sb_on = 1'b1;
  endtask

  task automatic test_wb_only();
    wb_write_en   = 1'b1;
    wb_write_dest = 3'd3;
    wb_write_data = 16'h1234;
    #1;
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 16'h1234}) begin
      bad++; $display("FAIL wb_only_port: got we=%b addr=%0d data=%h required 1/3/1234", rf_we, rf_waddr, rf_wdata);
    end
    total++; if (busy_vec !== 8'h00) begin bad++; $display("FAIL wb_only_busy: got %h required 00", busy_vec); end
    tick();
    idle();
  endtask

  task automatic test_issue_complete();
    mdu_issue      = 1'b1;
    mdu_issue_dest = 3'd5;
    #1;
    tick();
    idle();
    #1;
    total++; if (busy_vec !== 8'h20) begin bad++; $display("FAIL issue_busy: got %h required 20", busy_vec); end
    id_valid = 1'b1;
    id_rs1   = 3'd5;
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL stall_rs1: got %b required 1", id_stall); end
    id_rs1 = 3'd0;
    id_rd  = 3'd5;
    #1;
    total++; if (id_stall !== 1'b1) begin bad++; $display("FAIL stall_rd: got %b required 1", id_stall); end
    id_valid = 1'b0;
    #1;
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL stall_invalid: got %b required 0", id_stall); end
    id_valid  = 1'b1;
    id_rs1    = 3'd5;
    id_rd     = 3'd0;
    mdu_valid = 1'b1;
    mdu_dest  = 3'd5;
    mdu_data  = 16'hBEEF;
    tick();
    mdu_valid = 1'b0;
    #1;
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 16'hBEEF}) begin
      bad++; $display("FAIL drain_port: got we=%b addr=%0d data=%h required 1/5/BEEF", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    total++; if (busy_vec !== 8'h00) begin bad++; $display("FAIL drain_busy: got %h required 00", busy_vec); end
    total++; if (id_stall !== 1'b0) begin bad++; $display("FAIL drain_stall: got %b required 0", id_stall); end
    idle();
    tick();
  endtask

  task automatic test_collision();
    mdu_valid = 1'b1;
    mdu_dest  = 3'd2;
    mdu_data  = 16'h2222;
    #1;
    tick();
    mdu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_write_en   = 1'b1;
      wb_write_dest = 3'd4;
      wb_write_data = 16'h4440 + 16'(i);
      #1;
      total++; if (rf_waddr !== 3'd4) begin bad++; $display("FAIL collide_wb_wins: got %0d required 4", rf_waddr); end
      total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL collide_count1: got ready=%b required 1", mdu_ready); end
      tick();
    end
    idle();
    #1;
    total++; if (rf_waddr !== 3'd2) begin bad++; $display("FAIL collide_drain: got %0d required 2", rf_waddr); end
    total++; if (hold_pipe !== 1'b0) begin bad++; $display("FAIL collide_hold: got %b required 0", hold_pipe); end
    tick();
  endtask

  task automatic test_starvation();
    mdu_issue      = 1'b1;
    mdu_issue_dest = 3'd1;
    mdu_valid      = 1'b1;
    mdu_dest       = 3'd1;
    mdu_data       = 16'h1111;
    #1;
    tick();
    idle();
    for (int i = 1; i <= 4; i++) begin
      wb_write_en   = 1'b1;
      wb_write_dest = 3'd3;
      wb_write_data = 16'h3000 + 16'(i);
      #1;
      total++; if (hold_pipe !== 1'b0) begin bad++; $display("FAIL starve_early_c%0d: got %b required 0", i, hold_pipe); end
      tick();
    end
    wb_write_data = 16'h3005;
    #1;
    total++; if (hold_pipe !== 1'b1) begin bad++; $display("FAIL starve_hold: got %b required 1", hold_pipe); end
    tick();
    wb_write_en = 1'b0;
    #1;
    total++; if (hold_pipe !== 1'b1) begin bad++; $display("FAIL starve_saturate: got %b required 1", hold_pipe); end
    total++; if (rf_waddr !== 3'd1) begin bad++; $display("FAIL starve_drain: got %0d required 1", rf_waddr); end
    tick();
    total++; if (hold_pipe !== 1'b0) begin bad++; $display("FAIL starve_release: got %b required 0", hold_pipe); end
    total++; if (busy_vec !== 8'h00) begin bad++; $display("FAIL starve_busy: got %h required 00", busy_vec); end
  endtask

  task automatic test_full();
    wb_write_en   = 1'b1;
    wb_write_dest = 3'd7;
    wb_write_data = 16'h7001;
    mdu_valid     = 1'b1;
    mdu_dest      = 3'd6;
    mdu_data      = 16'h6666;
    #1;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL full_ready0: got %b required 1", mdu_ready); end
    tick();
    mdu_dest      = 3'd7;
    mdu_data      = 16'h7777;
    wb_write_data = 16'h7002;
    #1;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL full_ready1: got %b required 1", mdu_ready); end
    tick();
    mdu_dest      = 3'd0;
    mdu_data      = 16'h0A0A;
    wb_write_data = 16'h7003;
    #1;
    total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL full_not_ready: got %b required 0", mdu_ready); end
    tick();
    wb_write_en = 1'b0;
    #1;
    total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL full_conservative: got %b required 0", mdu_ready); end
    tick();
    wb_write_en   = 1'b1;
    wb_write_data = 16'h7004;
    #1;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL full_reopen: got %b required 1", mdu_ready); end
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      tick();
    end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL full_emptied: got we=%b required 0", rf_we); end
  endtask

  task automatic test_reset_mid();
    wb_write_en    = 1'b1;
    wb_write_dest  = 3'd1;
    wb_write_data  = 16'h0101;
    mdu_issue      = 1'b1;
    mdu_issue_dest = 3'd2;
    mdu_valid      = 1'b1;
    mdu_dest       = 3'd2;
    mdu_data       = 16'h2020;
    #1;
    tick();
    wb_write_data  = 16'h0102;
    mdu_issue_dest = 3'd3;
    mdu_dest       = 3'd3;
    mdu_data       = 16'h3030;
    #1;
    tick();
    mdu_issue = 1'b0;
    mdu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_write_data = 16'h0110 + 16'(i);
      #1;
      tick();
    end
    #1;
    total++; if (busy_vec !== 8'h0C) begin bad++; $display("FAIL mid_busy_pre: got %h required 0C", busy_vec); end
    total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_pre: got %b required 0", mdu_ready); end
    total++; if (hold_pipe !== 1'b1) begin bad++; $display("FAIL mid_hold_pre: got %b required 1", hold_pipe); end
    sb_on = 1'b0;
    rst   = 1'b0;
    #1;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b required 1", mdu_ready); end
    total++; if (busy_vec !== 8'h00) begin bad++; $display("FAIL mid_busy: got %h required 00", busy_vec); end
    total++; if (hold_pipe !== 1'b0) begin bad++; $display("FAIL mid_hold: got %b required 0", hold_pipe); end
    total++; if ({rf_we, rf_waddr} !== {1'b1, 3'd1}) begin
      bad++; $display("FAIL mid_we_wb: got we=%b addr=%0d required 1/1", rf_we, rf_waddr);
    end
    wb_write_en = 1'b0;
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_we_idle: got %b required 0", rf_we); end
    mfifo.delete();
    exp_q.delete();
    idle();
    @(posedge clk);
    #1;
    rst   = 1'b1;
    sb_on = 1'b1;
    #1;
    total++; if ({rf_we, busy_vec} !== {1'b0, 8'h00}) begin
      bad++; $display("FAIL mid_after: got we=%b busy=%h required 0/00", rf_we, busy_vec);
    end
    tick();
  endtask

  initial begin
    idle();
    fork
      sb_monitor();
    join_none
    test_reset();
    test_wb_only();
    test_issue_complete();
    test_collision();
    test_starvation();
    test_full();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the register-file write port and shares it between two requesters: the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- WB has absolute priority. MDU results are queued in a small FIFO and drained into idle write slots.
- An 8-bit busy scoreboard tracks registers awaiting MDU results and produces the decode-stage stall.
- A starvation counter requests a pipeline hold so that MDU results cannot wait forever.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive WB-won cycles with FIFO non-empty before hold_pipe asserts

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wb_write_en  in  1  WB stage write request
- wb_write_dest  in  ADDR_W  WB destination register
- wb_write_data  in  DATA_W  WB write data
- mdu_issue  in  1  MDU op accepted by decode this cycle
- mdu_issue_dest  in  ADDR_W  destination of issued MDU op
- mdu_valid  in  1  MDU result available
- mdu_dest  in  ADDR_W  MDU result destination
- mdu_data  in  DATA_W  MDU result data
- mdu_ready  out  1  FIFO can accept a result
- id_rs1, id_rs2, id_rd  in  ADDR_W each  decode-stage source and destination registers
- id_valid  in  1  decode holds a real instruction
- id_stall  out  1  decode must stall (operand or destination busy)
- hold_pipe  out  1  request to freeze fetch/decode so a bubble reaches WB
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- busy_vec  out  2**ADDR_W  scoreboard (debug/visibility)

Behaviour:

Reset (rst=0, asynchronous):
- FIFO empty, count=0; busy_vec=0; starvation counter=0; hold_pipe=0.
- Combinational outputs follow directly: mdu_ready=1, rf_we=wb_write_en, id_stall=0.

Write port (combinational):
- wb_write_en=1: rf_we=1, rf_waddr=wb_write_dest, rf_wdata=wb_write_data. FIFO does not pop.
- Otherwise, FIFO non-empty: rf_we=1, address/data come from the FIFO head, and the FIFO pops at the clock edge ("drain").
- Otherwise: rf_we=0, address/data=0.
- No special case for register 0.

FIFO:
- Push when mdu_valid && mdu_ready.
- mdu_ready = (count < DEPTH). Conservative: a same-cycle drain does not raise ready.
- Minimum MDU latency is 1 cycle: a pushed result is writable no earlier than the next cycle.
- Push and drain in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- While mdu_ready=0, the MDU holds mdu_valid and its data stable.

Scoreboard:
- mdu_issue sets busy[mdu_issue_dest].
- A drain clears busy[head dest].
- Set and clear of the same bit in the same cycle: set wins.
- One busy bit per register, no count. A second issue to an already-busy register is prevented by id_stall. If it happens anyway, the first drain clears the bit.

Decode stall (combinational):
- id_stall = id_valid && (busy[id_rs1] || busy[id_rs2] || busy[id_rd]).
- Checking id_rd prevents WAW reordering between WB and MDU writes.

Starvation:
- Counter increments when the FIFO is non-empty and wb_write_en=1.
- It resets to 0 on any drain or when the FIFO is empty.
- It saturates at STARVE_LIMIT.
- hold_pipe is registered: 1 when counter==STARVE_LIMIT, cleared the cycle after a drain.

Reset mid-operation:
- All queued MDU results and busy bits are discarded.
- The pipeline is flushed by the same reset.

Decomposition:
- Shared package (mips_pkg): DATA_W/ADDR_W constants and an rf_wr_t struct {dest, data}, shared with the WB stage and the register file.
- One sub-module, mdu_result_fifo: parameterised DEPTH, push/pop/full/empty/count, with an asynchronous active-low reset.
- Scoreboard, write-port mux and starvation logic stay in the top module.

Test Plan:
1. WB only: wb_write_en=1, dest=3, data=16'h1234, FIFO empty -> rf_we=1, rf_waddr=3, rf_wdata=16'h1234, busy_vec=0.
2. Issue/complete: mdu_issue dest=5 -> busy_vec=8'h20. Next cycle id_rs1=5, id_valid=1 -> id_stall=1. Then mdu_valid dest=5, data=16'hBEEF with WB idle -> cycle after: rf_we=1, rf_waddr=5, rf_wdata=16'hBEEF; following cycle busy_vec=0 and id_stall=0.
3. Collision: FIFO holds dest=2, and WB writes dest=4 for 3 cycles -> RF gets only WB writes, FIFO count stays 1. First WB-idle cycle writes r2.
4. Starvation: FIFO non-empty, wb_write_en=1 for 4 consecutive cycles -> hold_pipe=1 from the 5th cycle. Drop WB for one cycle -> drain, and hold_pipe=0 on the next cycle.
5. Full: two pushes with WB continuously busy -> mdu_ready=0, and a third mdu_valid is not accepted. One drain -> mdu_ready=1 the next cycle.
6. Reset mid-op: FIFO count=2, busy_vec=8'h0C, rst driven low asynchronously between edges -> immediately mdu_ready=1, busy_vec=0, hold_pipe=0, and rf_we follows wb_write_en only.
